pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use bubbles, redirect flushes, and
// stalls for multi-cycle ops and data-memory waits, with a wait watchdog.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_rs1_idx,
  input  logic [4:0]  id_rs2_idx,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        ex_long_start,
  input  logic        long_done,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        id_flush,
  output logic        ex_flush,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LONG = 2'd1,
    MEMW = 2'd2,
    BAD  = 2'd3
  } state_t;

  state_t     cur, nxt;
  logic       mw, lu, rs1_hit, rs2_hit;
  logic       pc_s, id_s, ex_s, mem_s, id_f, ex_f;
  logic [7:0] wait_cnt, wait_nxt;

  assign mw      = mem_req & ~mem_ready;
  assign rs1_hit = id_rs1_used & (id_rs1_idx == ex_rd);
  assign rs2_hit = id_rs2_used & (id_rs2_idx == ex_rd);
  assign lu      = ex_mem_read & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cur <= RUN;
    else       cur <= nxt;
  end

  always_comb begin
    nxt   = RUN;
    pc_s  = 1'b0;
    id_s  = 1'b0;
    ex_s  = 1'b0;
    mem_s = 1'b0;
    id_f  = 1'b0;
    ex_f  = 1'b0;
    case (cur)
      RUN: begin
        if (mw) begin
          {pc_s, id_s, ex_s, mem_s} = 4'b1111;
          nxt = MEMW;
        end else if (ex_redirect) begin
          id_f = 1'b1;
          ex_f = 1'b1;
        end else if (ex_long_start) begin
          {pc_s, id_s, ex_s} = 3'b111;
          nxt = LONG;
        end else if (lu) begin
          // one bubble: hold the consumer in ID, squash what enters EX
          pc_s = 1'b1;
          id_s = 1'b1;
          ex_f = 1'b1;
        end
      end
      LONG: begin
        if (mw) begin
          {pc_s, id_s, ex_s, mem_s} = 4'b1111;
          nxt = LONG;
        end else if (!long_done) begin
          {pc_s, id_s, ex_s} = 3'b111;
          nxt = LONG;
        end
      end
      MEMW: begin
        if (!mem_ready) begin
          {pc_s, id_s, ex_s, mem_s} = 4'b1111;
          nxt = MEMW;
        end
      end
      default: nxt = RUN;
    endcase
  end

  // reset overrides whatever the inputs would request
  assign pc_stall  = rstn & pc_s;
  assign id_stall  = rstn & id_s;
  assign ex_stall  = rstn & ex_s;
  assign mem_stall = rstn & mem_s;
  assign id_flush  = rstn & id_f;
  assign ex_flush  = rstn & ex_f;
  assign state     = cur;

  // only RUN can enter LONG/MEMW, so clearing in RUN covers every entry
  always_comb begin
    wait_nxt = 8'd0;
    if (cur == LONG || cur == MEMW)
      wait_nxt = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt    <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      if (wait_nxt == 8'hFF) timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cycles <= 32'd0;
    else if (pc_stall && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end

endmodule
